// File: rtl/board_engine_pkg.sv
// Shared types and constants for the 2048 board engine: FSM states, move
// directions, VGA tile-address map and board-index helpers.
package board_engine_pkg;

  localparam int EXP_W = 4;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SLIDE, S_SPAWN, S_CHECK} state_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  localparam logic [10:0] ADDR_ROW0_BASE = 11'h256;
  localparam logic [10:0] ADDR_MID_BASE  = 11'h260;
  localparam logic [10:0] ADDR_TAIL_BASE = 11'h270;
  localparam logic [10:0] ROW0_CELLS     = 11'd4;
  localparam logic [10:0] MID_CELLS      = 11'd10;
  localparam logic [10:0] TAIL_CELLS     = 11'd2;

  // Returns {hit, cell_index}; hit=0 for addresses outside the three tile windows.
  function automatic logic [4:0] addr_to_cell(input logic [10:0] addr);
    logic [10:0] off;
    logic [4:0]  res;
    res = '0;
    off = '0;
    if (addr >= ADDR_ROW0_BASE && addr < ADDR_ROW0_BASE + ROW0_CELLS) begin
      off = addr - ADDR_ROW0_BASE;
      res = {1'b1, off[3:0]};
    end else if (addr >= ADDR_MID_BASE && addr < ADDR_MID_BASE + MID_CELLS) begin
      off = addr - ADDR_MID_BASE;
      res = {1'b1, off[3:0] + 4'd4};
    end else if (addr >= ADDR_TAIL_BASE && addr < ADDR_TAIL_BASE + TAIL_CELLS) begin
      off = addr - ADDR_TAIL_BASE;
      res = {1'b1, off[3:0] + 4'd14};
    end
    return res;
  endfunction

  // Board index (row*4+col) of element k of the selected line, oriented so
  // element 0 is the cell tiles slide toward.
  function automatic logic [3:0] line_cell(input dir_t dir, input logic [1:0] line,
                                           input logic [1:0] k);
    logic [3:0] idx;
    case (dir)
      DIR_LEFT:  idx = {line, k};
      DIR_RIGHT: idx = {line, ~k};
      DIR_UP:    idx = {k, line};
      default:   idx = {~k, line};
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/board_engine_line_merge.sv
// Combinational 2048 line compressor: drops empties, merges equal neighbours
// once each toward element 0, and reports score delta, change and win.
module line_merge
  import board_engine_pkg::*;
#(
  parameter logic [3:0] WIN_EXP = 4'd11
) (
  input  logic [15:0] line_in,
  output logic [15:0] line_out,
  output logic [31:0] delta,
  output logic        changed,
  output logic        hit_win
);

  logic [3:0] packed_q [5];
  logic [2:0] n;
  logic [2:0] j;
  logic       skip;
  logic [3:0] m;

  always_comb begin
    for (int i = 0; i < 5; i++) packed_q[i] = '0;
    n        = '0;
    j        = '0;
    skip     = 1'b0;
    m        = '0;
    line_out = '0;
    delta    = '0;
    hit_win  = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (line_in[4*i +: 4] != 4'd0) begin
        packed_q[n] = line_in[4*i +: 4];
        n = n + 3'd1;
      end
    end

    // packed_q[4] is always zero, so element 3 never pairs with anything.
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (packed_q[i] != 4'd0) begin
        if (packed_q[i] == packed_q[i+1]) begin
          m = (packed_q[i] == 4'hF) ? 4'hF : packed_q[i] + 4'd1;
          line_out[4*j +: 4] = m;
          delta = delta + (32'd1 << m);
          if (m == WIN_EXP) hit_win = 1'b1;
          skip = 1'b1;
        end else begin
          line_out[4*j +: 4] = packed_q[i];
        end
        j = j + 3'd1;
      end
    end

    changed = (line_out != line_in);
  end

endmodule

// File: rtl/board_engine.sv
// 2048 game core: board registers, move/spawn/check FSM, spawn LFSR and the
// registered tile read port feeding the VGA controller.
module board_engine
  import board_engine_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [3:0]  WIN_EXP   = 4'd11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        ld_en,
  input  logic [3:0]  ld_idx,
  input  logic [3:0]  ld_val,
  input  logic [10:0] addrb,
  output logic [31:0] color,
  output logic [31:0] score,
  output logic        busy,
  output logic        won,
  output logic        game_over
);

  state_t      state_reg, state_next;
  dir_t        dir_reg, btn_dir;
  logic [1:0]  line_reg;
  logic        changed_reg;
  logic [3:0]  probe_reg, probe_cnt_reg, spawn_val_reg;
  logic        init_reg, init_second_reg;
  logic [15:0] lfsr_reg;
  logic [3:0]  board_reg [16];
  logic [31:0] score_reg, color_reg;
  logic        won_reg, game_over_reg;

  logic [3:0]  line_idx [4];
  logic [15:0] merge_in, merge_out;
  logic [31:0] merge_delta;
  logic        merge_changed, merge_win;
  logic [15:0] cell_zero, h_eq, v_eq;
  logic        no_move, any_btn, probe_empty, spawn_done;
  logic [4:0]  read_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_line
    assign line_idx[gi]       = line_cell(dir_reg, line_reg, 2'(gi));
    assign merge_in[4*gi +: 4] = board_reg[line_idx[gi]];
  end

  line_merge #(.WIN_EXP(WIN_EXP)) u_merge (
    .line_in  (merge_in),
    .line_out (merge_out),
    .delta    (merge_delta),
    .changed  (merge_changed),
    .hit_win  (merge_win)
  );

  for (genvar gi = 0; gi < 16; gi++) begin : g_cell
    assign cell_zero[gi] = (board_reg[gi] == 4'd0);
    if (gi % 4 != 3) begin : g_h
      assign h_eq[gi] = (board_reg[gi] == board_reg[gi+1]);
    end else begin : g_hn
      assign h_eq[gi] = 1'b0;
    end
    if (gi < 12) begin : g_v
      assign v_eq[gi] = (board_reg[gi] == board_reg[gi+4]);
    end else begin : g_vn
      assign v_eq[gi] = 1'b0;
    end
  end

  assign no_move     = ~(|cell_zero) & ~(|h_eq) & ~(|v_eq);
  assign any_btn     = btn_up | btn_down | btn_left | btn_right;
  assign btn_dir     = btn_up ? DIR_UP : btn_down ? DIR_DOWN : btn_left ? DIR_LEFT : DIR_RIGHT;
  assign probe_empty = (board_reg[probe_reg] == 4'd0);
  assign spawn_done  = probe_empty || (probe_cnt_reg == 4'd15);
  assign read_sel    = addr_to_cell(addrb);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_INIT:  state_next = S_SPAWN;
      S_IDLE:  if (!ld_en && !game_over_reg && any_btn) state_next = S_SLIDE;
      S_SLIDE: if (line_reg == 2'd3) state_next = (changed_reg || merge_changed) ? S_SPAWN : S_CHECK;
      S_SPAWN: if (spawn_done) state_next = init_reg ? (init_second_reg ? S_IDLE : S_INIT) : S_CHECK;
      S_CHECK: state_next = S_IDLE;
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_INIT;
      dir_reg         <= DIR_UP;
      line_reg        <= '0;
      changed_reg     <= 1'b0;
      probe_reg       <= '0;
      probe_cnt_reg   <= '0;
      spawn_val_reg   <= '0;
      init_reg        <= 1'b1;
      init_second_reg <= 1'b0;
      lfsr_reg        <= LFSR_SEED;
      score_reg       <= '0;
      color_reg       <= '0;
      won_reg         <= 1'b0;
      game_over_reg   <= 1'b0;
      for (int i = 0; i < 16; i++) board_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      lfsr_reg  <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
      color_reg <= {28'd0, read_sel[4] ? board_reg[read_sel[3:0]] : 4'd0};

      if (state_next == S_SPAWN && state_reg != S_SPAWN) begin
        probe_reg     <= lfsr_reg[3:0];
        probe_cnt_reg <= '0;
        spawn_val_reg <= (lfsr_reg[7:4] == 4'd0) ? 4'd2 : 4'd1;
      end

      case (state_reg)
        S_IDLE: begin
          if (ld_en) begin
            board_reg[ld_idx] <= ld_val;
          end else if (state_next == S_SLIDE) begin
            dir_reg     <= btn_dir;
            line_reg    <= '0;
            changed_reg <= 1'b0;
          end
        end
        S_SLIDE: begin
          for (int k = 0; k < 4; k++) board_reg[line_idx[k]] <= merge_out[4*k +: 4];
          score_reg   <= score_reg + merge_delta;
          won_reg     <= won_reg | merge_win;
          changed_reg <= changed_reg | merge_changed;
          line_reg    <= line_reg + 2'd1;
        end
        S_SPAWN: begin
          if (probe_empty) begin
            board_reg[probe_reg] <= spawn_val_reg;
          end else begin
            probe_reg     <= probe_reg + 4'd1;
            probe_cnt_reg <= probe_cnt_reg + 4'd1;
          end
          if (spawn_done && init_reg) begin
            if (init_second_reg) init_reg <= 1'b0;
            else init_second_reg <= 1'b1;
          end
        end
        S_CHECK: game_over_reg <= game_over_reg | no_move;
        default: ;
      endcase
    end
  end

  assign color     = color_reg;
  assign score     = score_reg;
  assign busy      = (state_reg != S_IDLE);
  assign won       = won_reg;
  assign game_over = game_over_reg;

endmodule

// File: tb/tb_board_engine.sv
// Self-checking bench for board_engine: directed line vectors, game-over,
// read-port and reset sequences, then random moves against a queue-based model.
module tb_board_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_up, btn_down, btn_left, btn_right;
  logic        ld_en;
  logic [3:0]  ld_idx, ld_val;
  logic [10:0] addrb;
  logic [31:0] color, score;
  logic        busy, won, game_over;

  board_engine dut (
    .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .ld_en(ld_en), .ld_idx(ld_idx), .ld_val(ld_val), .addrb(addrb),
    .color(color), .score(score), .busy(busy), .won(won), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef int board_t [16];
  typedef struct {
    logic [15:0] row_in;   // leftmost cell in the top nibble
    logic [15:0] row_exp;
    logic [31:0] delta;
    bit          win;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] score_m;
  bit          won_m, go_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [10:0] cell_addr(input int i);
    if (i < 4) return 11'h256 + 11'(i);
    if (i < 14) return 11'h260 + 11'(i - 4);
    return 11'h270 + 11'(i - 14);
  endfunction

  // Reference: each line is read outward from the wall, squeezed and merged with a queue.
  function automatic void merge_model(input board_t in, input int dir, output board_t out,
                                      output logic [31:0] delta, output bit win);
    int idx [4];
    int q [$];
    int res [$];
    int v;
    delta = 0;
    win = 0;
    out = in;
    for (int line = 0; line < 4; line++) begin
      for (int k = 0; k < 4; k++) begin
        case (dir)
          0:       idx[k] = 4 * k + line;
          1:       idx[k] = 4 * (3 - k) + line;
          2:       idx[k] = 4 * line + k;
          default: idx[k] = 4 * line + 3 - k;
        endcase
      end
      q.delete();
      res.delete();
      for (int k = 0; k < 4; k++) if (in[idx[k]] != 0) q.push_back(in[idx[k]]);
      while (q.size() > 0) begin
        if (q.size() >= 2 && q[0] == q[1]) begin
          v = (q[0] + 1 > 15) ? 15 : q[0] + 1;
          res.push_back(v);
          delta += 32'd1 << v;
          if (v == 11) win = 1;
          void'(q.pop_front());
          void'(q.pop_front());
        end else begin
          res.push_back(q.pop_front());
        end
      end
      while (res.size() < 4) res.push_back(0);
      for (int k = 0; k < 4; k++) out[idx[k]] = res[k];
    end
  endfunction

  function automatic bit no_moves(input board_t b);
    for (int i = 0; i < 16; i++) begin
      if (b[i] == 0) return 0;
      if (i % 4 != 3 && b[i] == b[i+1]) return 0;
      if (i < 12 && b[i] == b[i+4]) return 0;
    end
    return 1;
  endfunction

  task automatic load_board(input board_t b);
    for (int i = 0; i < 16; i++) begin
      ld_en = 1'b1; ld_idx = 4'(i); ld_val = 4'(b[i]);
      @(negedge clk);
    end
    ld_en = 1'b0;
  endtask

  task automatic read_board(output board_t b);
    for (int i = 0; i < 16; i++) begin
      addrb = cell_addr(i);
      @(negedge clk);
      b[i] = int'(color[3:0]);
    end
  endtask

  task automatic press(input logic [3:0] btns);
    {btn_up, btn_down, btn_left, btn_right} = btns;
    @(negedge clk);
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic check_init(input string name);
    board_t b;
    int nz = 0, bad = 0;
    read_board(b);
    for (int i = 0; i < 16; i++) begin
      if (b[i] != 0) nz++;
      if (b[i] != 0 && b[i] != 1 && b[i] != 2) bad++;
    end
    check({name, "_init_tiles"}, nz, 2);
    check({name, "_init_values"}, bad, 0);
    check({name, "_init_score"}, score, 32'd0);
    check({name, "_init_flags"}, {won, game_over}, 32'd0);
    $display("init %s: %0d tiles, score %0d", name, nz, score);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check({name, "_rst_busy"}, 32'(busy), 32'd1);
    check({name, "_rst_score"}, score, 32'd0);
    check({name, "_rst_color"}, color, 32'd0);
    rst = 1'b0;
    score_m = 0; won_m = 0; go_m = 0;
    repeat (40) @(negedge clk);
    check({name, "_init_busy"}, 32'(busy), 32'd0);
    wait_idle(name);
    check_init(name);
  endtask

  // Apply one move and compare against exp (the slid board before any spawn).
  task automatic run_move(input string name, input board_t start, input logic [3:0] btns,
                          input board_t exp, input logic [31:0] exp_delta, input bit exp_win);
    board_t act, fin;
    int bad = 0, spawns = 0, exp_sp = 0;
    bit chg = 0;
    for (int i = 0; i < 16; i++) if (exp[i] != start[i]) chg = 1;
    if (chg) for (int i = 0; i < 16; i++) if (exp[i] == 0) exp_sp = 1;
    load_board(start);
    press(btns);
    check({name, "_busy"}, 32'(busy), 32'd1);
    wait_idle(name);
    read_board(act);
    for (int i = 0; i < 16; i++) begin
      if (act[i] != exp[i]) begin
        if (exp[i] == 0 && (act[i] == 1 || act[i] == 2)) spawns++;
        else bad++;
      end
    end
    check({name, "_cells"}, bad, 0);
    check({name, "_spawn"}, spawns, exp_sp);
    fin = (bad == 0 && spawns == exp_sp) ? act : exp;
    score_m += exp_delta;
    won_m |= exp_win;
    go_m = no_moves(fin);
    check({name, "_score"}, score, score_m);
    check({name, "_won"}, 32'(won), 32'(won_m));
    check({name, "_game_over"}, 32'(game_over), 32'(go_m));
    $display("move %s btns=%b delta=%0d score=%0d won=%0d over=%0d", name, btns, exp_delta,
             score, won, game_over);
  endtask

  vec_t vecs [9];
  board_t sb, eb, cb, kb, rb;
  logic [31:0] d;
  bit w;
  logic [3:0] btns;
  int dir;
  logic [10:0] raddr [12];
  int rexp [12];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h1111, 16'h2200, 32'd8, 1'b0};
    vecs[1] = '{16'h1120, 16'h2200, 32'd4, 1'b0};
    vecs[2] = '{16'h0101, 16'h2000, 32'd4, 1'b0};
    vecs[3] = '{16'h1234, 16'h1234, 32'd0, 1'b0};
    vecs[4] = '{16'h2022, 16'h3200, 32'd8, 1'b0};
    vecs[5] = '{16'hFF00, 16'hF000, 32'd32768, 1'b0};
    vecs[6] = '{16'hAA00, 16'hB000, 32'd2048, 1'b1};
    vecs[7] = '{16'h3303, 16'h4300, 32'd16, 1'b0};
    vecs[8] = '{16'h0001, 16'h1000, 32'd0, 1'b0};

    rst = 1'b1; ld_en = 1'b0; ld_idx = '0; ld_val = '0; addrb = '0;
    {btn_up, btn_down, btn_left, btn_right} = 4'b0000;
    do_reset("power_on");

    // Row 0 vectors slid left on an otherwise empty board.
    foreach (vecs[v]) begin
      for (int i = 0; i < 16; i++) begin
        sb[i] = (i < 4) ? int'(vecs[v].row_in[15-4*i -: 4]) : 0;
        eb[i] = (i < 4) ? int'(vecs[v].row_exp[15-4*i -: 4]) : 0;
      end
      run_move($sformatf("vec%0d", v), sb, 4'b0010, eb, vecs[v].delta, vecs[v].win);
    end

    // Locked checkerboard: no change, no spawn, game over, then buttons ignored.
    for (int i = 0; i < 16; i++) cb[i] = ((i / 4 + i % 4) % 2 != 0) ? 2 : 1;
    run_move("checker", cb, 4'b0001, cb, 32'd0, 1'b0);
    press(4'b1000);
    check("ignored_busy", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    read_board(rb);
    begin
      int diffs = 0;
      for (int i = 0; i < 16; i++) if (rb[i] != cb[i]) diffs++;
      check("ignored_board", diffs, 0);
    end
    do_reset("after_over");

    // Read port map, including holes between windows.
    for (int i = 0; i < 16; i++) kb[i] = (i % 15) + 1;
    load_board(kb);
    raddr = '{11'h256, 11'h259, 11'h260, 11'h269, 11'h270, 11'h271,
              11'h25A, 11'h25F, 11'h26A, 11'h255, 11'h272, 11'h000};
    rexp  = '{kb[0], kb[3], kb[4], kb[13], kb[14], kb[15], 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      addrb = raddr[i];
      @(negedge clk);
      check($sformatf("read_%03h", raddr[i]), color, 32'(rexp[i]));
      $display("read addr=%03h color=%0d", raddr[i], color);
    end

    // Random boards and button combinations against the model.
    for (int t = 0; t < 40; t++) begin
      if (go_m) do_reset($sformatf("rnd_rst%0d", t));
      for (int i = 0; i < 16; i++) begin
        int r = $urandom_range(0, 99);
        if (r < 30 && t % 8 != 7) sb[i] = 0;
        else if (r < 85) sb[i] = $urandom_range(1, 4);
        else if (r < 95) sb[i] = $urandom_range(9, 11);
        else sb[i] = $urandom_range(14, 15);
      end
      btns = 4'($urandom_range(1, 15));
      dir = btns[3] ? 0 : btns[2] ? 1 : btns[1] ? 2 : 3;
      merge_model(sb, dir, eb, d, w);
      run_move($sformatf("rnd%0d", t), sb, btns, eb, d, w);
    end

    // Reset one cycle into a slide that has already scored.
    if (go_m) do_reset("pre_mid");
    for (int i = 0; i < 16; i++) sb[i] = (i < 4) ? 1 : 0;
    load_board(sb);
    press(4'b0010);
    @(negedge clk);
    do_reset("mid_slide");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
